// File: rtl/key_event.sv
// key_event: turns the debounced key level into one-cycle gesture pulses.
// press/release on every edge; click, double, long and repeat by hold timing.
module key_event #(
  parameter int unsigned N        = 20,
  parameter int unsigned T_LONG   = 1_000_000,
  parameter int unsigned T_DOUBLE = 500_000,
  parameter int unsigned T_REPEAT = 250_000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic press_evt,
  output logic release_evt,
  output logic click_evt,
  output logic double_evt,
  output logic long_evt,
  output logic repeat_evt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_GAP  = 3'd2,
    S_LONG = 3'd3,
    S_DBL  = 3'd4
  } state_t;

  localparam logic [N-1:0] LONG_END = N'(T_LONG - 1);
  localparam logic [N-1:0] DBL_END  = N'(T_DOUBLE - 1);
  localparam logic [N-1:0] REP_END  = N'(T_REPEAT - 1);
  localparam logic [N-1:0] ONE      = N'(1);

  state_t       state;
  logic [N-1:0] cnt;
  logic         din_d;
  logic         rise;
  logic         fall;

  assign rise = din & ~din_d;
  assign fall = ~din & din_d;

  // A timeout compare of cnt==T-1 lands exactly T edges after entry,
  // because entry clears cnt and each following edge adds one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      din_d       <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      click_evt   <= 1'b0;
      double_evt  <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
    end else begin
      din_d       <= din;
      press_evt   <= rise;
      release_evt <= fall;
      click_evt   <= 1'b0;
      double_evt  <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (fall) begin
            state <= S_GAP;
            cnt   <= '0;
          end else if (cnt == LONG_END) begin
            long_evt <= 1'b1;
            state    <= S_LONG;
            cnt      <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_GAP: begin
          if (rise) begin
            double_evt <= 1'b1;
            state      <= S_DBL;
            cnt        <= '0;
          end else if (cnt == DBL_END) begin
            click_evt <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_LONG: begin
          if (fall) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == REP_END) begin
            repeat_evt <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DBL: begin
          cnt <= '0;
          if (fall) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          press_evt   <= 1'b0;
          release_evt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: random and directed gestures against a timestamp model.
// Expected pulses are queued per edge and compared by a separate monitor.
module tb_key_event;

  localparam int TL = 10;
  localparam int TD = 6;
  localparam int TR = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic din = 1'b0;
  logic press_evt, release_evt, click_evt;
  logic double_evt, long_evt, repeat_evt;

  key_event #(.N(8), .T_LONG(TL), .T_DOUBLE(TD), .T_REPEAT(TR)) dut (
    .clk(clk), .n_rst(n_rst), .din(din),
    .press_evt(press_evt), .release_evt(release_evt),
    .click_evt(click_evt), .double_evt(double_evt),
    .long_evt(long_evt), .repeat_evt(repeat_evt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int n_ev[6];
  int last_ev[6];
  logic [5:0] expq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 6; i++) begin
      n_ev[i] = 0;
      last_ev[i] = -1;
    end
  endtask

  // Reference model: gesture phase plus timestamps of press/release/repeat.
  typedef enum {M_IDLE, M_HELD, M_WAIT, M_LONG, M_SECOND} mph_e;
  initial begin : model
    mph_e ph = M_IDLE;
    int now = 0, t_press = 0, t_rel = 0, t_rep = 0;
    logic prev = 1'b0;
    logic rise, fall;
    logic [5:0] e;
    forever begin
      @(posedge clk);
      e = '0;
      if (!n_rst) begin
        ph = M_IDLE;
        prev = 1'b0;
        now = 0;
      end else begin
        now++;
        rise = din && !prev;
        fall = !din && prev;
        prev = din;
        e[0] = rise;
        e[1] = fall;
        case (ph)
          M_IDLE: if (rise) begin ph = M_HELD; t_press = now; end
          M_HELD:
            if (fall) begin ph = M_WAIT; t_rel = now; end
            else if (now - t_press == TL) begin
              e[4] = 1'b1; ph = M_LONG; t_rep = now + TR;
            end
          M_WAIT:
            if (rise) begin e[3] = 1'b1; ph = M_SECOND; end
            else if (now - t_rel == TD) begin e[2] = 1'b1; ph = M_IDLE; end
          M_LONG:
            if (fall) ph = M_IDLE;
            else if (now == t_rep) begin e[5] = 1'b1; t_rep = now + TR; end
          M_SECOND: if (fall) ph = M_IDLE;
          default: ph = M_IDLE;
        endcase
      end
      expq.push_back(e);
    end
  end

  initial begin : monitor
    logic [5:0] act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (n_rst) ecnt++;
      else ecnt = 0;
      act = {repeat_evt, long_evt, double_evt,
             click_evt, release_evt, press_evt};
      for (int i = 0; i < 6; i++)
        if (act[i]) begin n_ev[i]++; last_ev[i] = ecnt; end
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got pulses %b expected a queued entry", act);
      end else begin
        exp = expq.pop_front();
        check("pulses", int'(act), int'(exp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl);
    n_rst = 1'b0;
    din = lvl;
    idle(3);
    n_rst = 1'b1;
    clear_stats();
  endtask

  task automatic drive(input int e, input logic v);
    int k = 0;
    while (ecnt != e - 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: edge %0d reached %0d", e, ecnt);
    end
    din = v;
  endtask

  initial begin
    int rises, d, cyc;
    clear_stats();
    idle(3);
    check("reset_out", int'({press_evt, release_evt, click_evt,
          double_evt, long_evt, repeat_evt}), 0);

    // single click
    do_reset(1'b0);
    drive(5, 1'b1); drive(8, 1'b0); idle(20);
    check("t1_press", last_ev[0], 5);
    check("t1_rel", last_ev[1], 8);
    check("t1_click", last_ev[2], 14);
    check("t1_nclick", n_ev[2], 1);
    check("t1_other", n_ev[3] + n_ev[4] + n_ev[5], 0);

    // double click
    do_reset(1'b0);
    drive(5, 1'b1); drive(8, 1'b0); drive(11, 1'b1); drive(13, 1'b0);
    idle(20);
    check("t2_npress", n_ev[0], 2);
    check("t2_double", last_ev[3], 11);
    check("t2_rel", last_ev[1], 13);
    check("t2_noclick", n_ev[2], 0);

    // long press with repeats, last repeat masked by release
    do_reset(1'b0);
    drive(5, 1'b1); drive(27, 1'b0); idle(20);
    check("t3_long", last_ev[4], 15);
    check("t3_nrep", n_ev[5], 2);
    check("t3_lastrep", last_ev[5], 23);
    check("t3_rel", last_ev[1], 27);
    check("t3_noclick", n_ev[2], 0);

    // release on the long timeout edge
    do_reset(1'b0);
    drive(5, 1'b1); drive(15, 1'b0); idle(20);
    check("t4_nolong", n_ev[4], 0);
    check("t4_click", last_ev[2], 21);

    // re-press on the click timeout edge
    do_reset(1'b0);
    drive(5, 1'b1); drive(8, 1'b0); drive(14, 1'b1); drive(16, 1'b0);
    idle(20);
    check("t4_double", last_ev[3], 14);
    check("t4_noclick", n_ev[2], 0);

    // reset while waiting for the click timeout
    do_reset(1'b0);
    drive(5, 1'b1); drive(8, 1'b0); drive(10, 1'b0);
    n_rst = 1'b0;
    #1;
    check("t5_rst_out", int'({press_evt, release_evt, click_evt,
          double_evt, long_evt, repeat_evt}), 0);
    idle(3);
    n_rst = 1'b1;
    clear_stats();
    idle(20);
    check("t5_noclick", n_ev[2] + n_ev[0] + n_ev[1], 0);

    // key already held at reset release
    do_reset(1'b1);
    idle(3);
    check("t5_press_first", last_ev[0], 1);
    check("t5_npress", n_ev[0], 1);
    din = 1'b0;
    idle(20);

    // asynchronous clear of a live pulse
    do_reset(1'b0);
    drive(5, 1'b1);
    @(posedge clk);
    #2;
    check("t5_press_live", int'(press_evt), 1);
    n_rst = 1'b0;
    #1;
    check("t5_async_clr", int'(press_evt), 0);
    din = 1'b0;
    idle(3);

    // random gestures
    do_reset(1'b0);
    rises = 0;
    cyc = 0;
    while (cyc < 10000) begin
      d = $urandom_range(1, 16);
      din = ~din;
      if (din) rises++;
      idle(d);
      cyc += d;
    end
    din = 1'b0;
    idle(20);
    check("t6_press_rise", n_ev[0], rises);
    check("t6_excl", int'((n_ev[2] + n_ev[3] + n_ev[4]) <= (n_ev[0] - n_ev[3])), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Classifies the debounced key level from the debounce stage into single-cycle event pulses: press, release, single click, double click, long press and auto-repeat.
- Sits directly downstream of the debounce stage. Its outputs feed the control FSM and counters of the application logic.
- All outputs are registered, one clock domain.

Parameters:
T_LONG, 20'hF_4240 (1_000_000), hold cycles from press before long_evt
T_DOUBLE, 20'h7_A120 (500_000), max cycles from release to second press for double_evt
T_REPEAT, 20'h3_D090 (250_000), cycles between repeat_evt pulses while long-held
N, 20, counter width; every T_* is >= 2 and < 2^N

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
din  input  1  debounced key level (1 = pressed), synchronous to clk
press_evt  output  1  one-cycle pulse on each press
release_evt  output  1  one-cycle pulse on each release
click_evt  output  1  one-cycle pulse: short press with no second press in the window
double_evt  output  1  one-cycle pulse: second press within T_DOUBLE of a short release
long_evt  output  1  one-cycle pulse: key held T_LONG cycles
repeat_evt  output  1  one-cycle pulse every T_REPEAT cycles after long_evt while held

Behaviour:
- Reset (async assert, sync deassert by clk): state=S_IDLE, cnt=0, din_d=0, all outputs 0.
- din_d <= din each cycle.
  - rise = din & ~din_d; fall = ~din & din_d (combinational).
  - Every output register is set at the clk edge where its condition holds and is cleared at the next edge. Latency from the sampled din change is one edge; no pulse is wider than 1 cycle.
- cnt:
  - Cleared to 0 on every state entry and on each repeat_evt.
  - Otherwise increments by 1 each cycle in S_HOLD, S_GAP and S_LONG.
  - A timeout "cnt==T-1" fires exactly T cycles after the entry edge.
  - Held at 0 in S_IDLE and S_DBL. cnt never wraps: the legal T range guarantees this.
- press_evt is set on every rise. release_evt is set on every fall. Both fire in every state.
- State S_IDLE:
  - rise -> S_HOLD.
- State S_HOLD:
  - fall -> S_GAP.
  - Else cnt==T_LONG-1 -> long_evt, S_LONG.
  - If fall and timeout occur on the same edge, fall wins: no long_evt, goes to S_GAP.
- State S_GAP:
  - rise -> double_evt, S_DBL.
  - Else cnt==T_DOUBLE-1 -> click_evt, S_IDLE.
  - If rise and timeout occur on the same edge, rise wins: double_evt only.
- State S_LONG:
  - fall -> S_IDLE. No click_evt.
  - Else cnt==T_REPEAT-1 -> repeat_evt, cnt cleared, stays in S_LONG.
  - If fall and repeat timeout occur on the same edge, fall wins.
- State S_DBL:
  - fall -> S_IDLE.
  - No long, repeat or click is generated for the second press.
- Unused state encoding -> S_IDLE, cnt=0, no outputs.
- Boundary cases:
  - din high at reset release: rise is seen at the first edge, so press_evt fires and the state goes to S_HOLD.
  - Reset mid-sequence abandons any pending click or long; no event is emitted on reset exit except the case above.
- Per gesture, exactly one of click_evt, double_evt or long_evt fires, or none if reset intervenes.

Test Plan (T_LONG=10, T_DOUBLE=6, T_REPEAT=4, N=8):
1. Reset with din=0, then din=1 at edge 5 and din=0 at edge 8.
   - Required: press_evt at 5, release_evt at 8, click_evt at 14.
   - No other pulses; all outputs 0 throughout reset.
2. din=1 at edge 5, din=0 at edge 8, din=1 at edge 11, din=0 at edge 13.
   - Required: press_evt at 5 and 11, double_evt at 11, release_evt at 8 and 13.
   - No click_evt; state is S_IDLE after 13.
3. din=1 at edge 5, held until din=0 at edge 27.
   - Required: press_evt at 5, long_evt at 15, repeat_evt at 19, 23 (and 27 suppressed by fall), release_evt at 27.
   - No click_evt.
4. Same-edge priority:
   - din=1 at 5, din=0 at 15: release_evt at 15, no long_evt, click_evt at 21.
   - Second run: release at 8, re-press at 14: double_evt at 14, no click_evt.
5. Reset mid-operation:
   - n_rst low at edge 10 while in S_GAP (press 5, release 8), din=0: outputs 0 immediately (async) and no click_evt ever.
   - n_rst low with din held 1, then released: press_evt at the first edge after reset release.
6. Pulse width and mutual exclusion: random din of ≥1-cycle levels for 10k cycles.
   - Every output is high ≤1 cycle; press_evt count equals rise count.
   - click + double + long count ≤ number of press_evt pulses not flagged double.
